tx_ordering_scheduler: RTL and testbench
========================================

# tx_ordering_scheduler

Sequencer between the TX Posted, Non-Posted and Completion head-of-queue entries and the TLP transmit path. It tracks arrival age per class and grants the oldest class that holds flow-control credit. A younger class is granted only after the ordering checker confirms, through `ordering_if`, that it may pass every older pending class. Each grant is held until the transmit path reports the TLP done. A starvation counter bounds how often the oldest entry can be bypassed.

## Interface
Parameters:
- `REQUESTER_ID_WIDTH`, from `Tx_Arbiter_Package`: requester/completer ID width.
- `STARVE_LIMIT`, default 8: maximum consecutive bypasses of the oldest entry.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  reset, synchronous and active-high.
- `p_valid`, `np_valid`, `cpl_valid`  in  1 each  head entry of class present.
- `p_ro`/`p_ido`, `np_ro`/`np_ido`, `cpl_ro`/`cpl_ido`  in  1 each  head Attr RO (Attr[1]) and IDO (Attr[2]).
- `p_id`, `np_id`, `cpl_id`  in  `REQUESTER_ID_WIDTH`  head requester/completer ID.
- `cpl_comp_typ`  in  3  completion type: 001 IO_wr, 010 CFG_wr, 011 MEM_wr, 100 IO_rd, 101 CFG_rd, 110 MEM_rd.
- `p_fc_ok`, `np_fc_ok`, `cpl_fc_ok`  in  1 each  credit available for the class.
- `grant`  out  3  one-hot grant, bit order {CPL, NP, P}.
- `tlp_done`  in  1  granted TLP fully transmitted.
- `ord`  `ordering_if.ARBITER_ORDERING_IF`  pairwise ordering query. `ordering_result` is combinational and is sampled in the cycle it is driven.

## Operation
- **Age list:** 3 slots of 2-bit class codes plus a 2-bit count.
  - A class is appended at the tail in the cycle its valid is first seen while it is not already listed.
  - Simultaneous appends go in the order P, NP, CPL (P oldest).
  - On `tlp_done`, the granted class is removed and younger slots shift toward the head.
  - A class whose valid deasserts without a grant is removed in the same way.
- **FSM states:**
  - **IDLE:** go to EVAL when count ≠ 0.
  - **EVAL:** set cand = head slot.
    - If cand has credit (`fc_ok`), go to GRANT.
    - Otherwise advance cand to the next slot and go to CHECK, provided a next slot exists and `starve_cnt < STARVE_LIMIT`.
    - Otherwise stay in EVAL and re-evaluate next cycle.
  - **CHECK:** one pair per cycle.
    - `first_trans` = each older slot, iterating from the head; `second_trans` = cand.
    - The RO/IDO/ID of each side come from its class. `comp_typ` = `cpl_comp_typ` always.
    - If every older pair returns TRUE and cand has `fc_ok`, go to GRANT and increment `starve_cnt` (saturating).
    - On any FALSE, or no credit: advance to the next younger slot and repeat CHECK. If no slot remains, return to EVAL.
  - **GRANT:** drive one-hot `grant` for the selected class; go to BUSY. Granting the head clears `starve_cnt`.
  - **BUSY:** hold `grant`. On `tlp_done`, clear `grant`, update the age list, and go to IDLE.
- Only one grant is ever outstanding, and `grant` is always one-hot or zero.
- Changes to an ungranted head's attributes or validity during CHECK take effect at the next CHECK cycle; the ongoing pair sequence is not restarted.
- `tlp_done` outside BUSY is ignored.

## Timing
- Reset values:
  - `grant` = 0; FSM = IDLE; age list empty; `starve_cnt` = 0.
  - All `ord` outputs = 0, with `first_trans`/`second_trans` at the Posted encoding.
- Reset asserted in any state: on the next edge, everything returns to reset values and a held `grant` drops.
- Latency, valid to grant, with an idle FSM:
  - Oldest class with credit: 3 cycles (append, EVAL, GRANT).
  - Bypass of one older entry: 4 cycles.
  - Bypass of two older entries: 5 cycles.
- `grant` falls the cycle after `tlp_done` is sampled. The next grant comes no earlier than 3 cycles later.
- `ord` outputs are registered and stable through each CHECK cycle.

## Structure
- `Tx_Arbiter_Package` holds:
  - `Req_Type_t` (existing).
  - `REQUESTER_ID_WIDTH` (existing).
  - New `sched_state_t` {IDLE, EVAL, CHECK, GRANT, BUSY}.
  - New 2-bit class code constants CLS_P, CLS_NP, CLS_CPL.
- Sub-module `tx_age_list`: the 3-slot append/remove/shift list with count.

## Test plan
- Only `p_valid` with `p_fc_ok`=1 at cycle 0 -> `grant`=001 at cycle 3; `tlp_done` at 6 -> `grant`=000 at 7; list empty.
- P then NP (one cycle apart), `p_fc_ok`=0, `np_fc_ok`=1, ordering returns TRUE -> one CHECK with first=P, second=NP; `grant`=010; `starve_cnt`=1.
- Same as previous but ordering returns FALSE -> no grant. Raise `p_fc_ok` -> `grant`=001.
- P, NP and CPL arrive in the same cycle, P and NP without credit -> CHECK pairs (P,CPL) then (NP,CPL); `comp_typ`=`cpl_comp_typ` (e.g. 010); `grant`=100.
- Oldest blocked, a younger class repeatedly refilled with all ordering TRUE -> exactly 8 bypasses, then EVAL waits on the head until it gets credit.
- Reset asserted in BUSY -> `grant`=000 next edge; list empty; `ord` outputs zero.

Source files
------------

// File: rtl/tx_ordering_scheduler_pkg.sv
// Shared types and constants for the TX arbiter: request classes, scheduler states
// and the ordering-query side descriptor.
package Tx_Arbiter_Package;

    localparam int unsigned REQUESTER_ID_WIDTH = 16;

    typedef enum logic [1:0] {
        POSTED     = 2'd0,
        NON_POSTED = 2'd1,
        COMPLETION = 2'd2
    } Req_Type_t;

    typedef enum logic [2:0] {
        IDLE,
        EVAL,
        CHECK,
        GRANT,
        BUSY
    } sched_state_t;

    localparam logic [1:0] CLS_P   = 2'd0;
    localparam logic [1:0] CLS_NP  = 2'd1;
    localparam logic [1:0] CLS_CPL = 2'd2;

    typedef struct packed {
        logic [1:0]                    trans;
        logic                          ro;
        logic                          ido;
        logic [REQUESTER_ID_WIDTH-1:0] id;
    } side_t;

    function automatic logic [2:0] cls_onehot(input logic [1:0] cls);
        return (cls == 2'd3) ? 3'b000 : (3'b001 << cls);
    endfunction

endpackage

// File: rtl/ordering_if.sv
// Pairwise ordering query between the scheduler and the ordering checker.
interface ordering_if;
    import Tx_Arbiter_Package::*;

    Req_Type_t                     first_trans;
    logic                          first_ro;
    logic                          first_ido;
    logic [REQUESTER_ID_WIDTH-1:0] first_id;
    Req_Type_t                     second_trans;
    logic                          second_ro;
    logic                          second_ido;
    logic [REQUESTER_ID_WIDTH-1:0] second_id;
    logic [2:0]                    comp_typ;
    logic                          ordering_result;

    modport ARBITER_ORDERING_IF (
        output first_trans, first_ro, first_ido, first_id,
        output second_trans, second_ro, second_ido, second_id, comp_typ,
        input  ordering_result
    );

    modport ORDERING_CHECKER (
        input  first_trans, first_ro, first_ido, first_id,
        input  second_trans, second_ro, second_ido, second_id, comp_typ,
        output ordering_result
    );
endinterface

// File: rtl/tx_ordering_scheduler_age_list.sv
// Three-slot arrival-age list of class codes: slot 0 is the oldest class.
module tx_age_list
    import Tx_Arbiter_Package::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [2:0]      append_req,
    input  logic [2:0]      remove_req,
    output logic [2:0][1:0] slots,
    output logic [1:0]      count,
    output logic [2:0]      listed
);

    logic [2:0][1:0] slots_q, slots_d;
    logic [1:0]      count_q, count_d;

    // Survivors close up toward slot 0 in order; new arrivals follow in P, NP, CPL order.
    always_comb begin
        slots_d = '0;
        count_d = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            if (i < 32'(count_q) && !remove_req[slots_q[i[1:0]]] && count_d != 2'd3) begin
                slots_d[count_d] = slots_q[i[1:0]];
                count_d          = count_d + 2'd1;
            end
        end
        for (int unsigned c = 0; c < 3; c++) begin
            if (append_req[c[1:0]] && count_d != 2'd3) begin
                slots_d[count_d] = c[1:0];
                count_d          = count_d + 2'd1;
            end
        end
    end

    always_comb begin
        listed = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            if (i < 32'(count_q)) listed = listed | cls_onehot(slots_q[i[1:0]]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slots_q <= '0;
            count_q <= '0;
        end else begin
            slots_q <= slots_d;
            count_q <= count_d;
        end
    end

    assign slots = slots_q;
    assign count = count_q;

endmodule

// File: rtl/tx_ordering_scheduler.sv
// Age-ordered grant sequencer for the TX Posted / Non-Posted / Completion heads,
// with ordering-checked bypass of credit-blocked older classes.
module tx_ordering_scheduler
    import Tx_Arbiter_Package::*;
#(
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          p_valid,
    input  logic                          np_valid,
    input  logic                          cpl_valid,
    input  logic                          p_ro,
    input  logic                          p_ido,
    input  logic                          np_ro,
    input  logic                          np_ido,
    input  logic                          cpl_ro,
    input  logic                          cpl_ido,
    input  logic [REQUESTER_ID_WIDTH-1:0] p_id,
    input  logic [REQUESTER_ID_WIDTH-1:0] np_id,
    input  logic [REQUESTER_ID_WIDTH-1:0] cpl_id,
    input  logic [2:0]                    cpl_comp_typ,
    input  logic                          p_fc_ok,
    input  logic                          np_fc_ok,
    input  logic                          cpl_fc_ok,
    output logic [2:0]                    grant,
    input  logic                          tlp_done,
    ordering_if.ARBITER_ORDERING_IF       ord
);

    localparam int unsigned SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    logic [2:0]      valid_v, fc_v;
    side_t [2:0]     side_v;
    logic [2:0][1:0] slots;
    logic [1:0]      count;
    logic [2:0]      listed, append_req, remove_req;

    sched_state_t    state_q, state_d;
    logic [1:0]      cand_q, cand_d, pair_q, pair_d;
    logic [SW-1:0]   starve_q, starve_d;
    logic [2:0]      grant_q, grant_d;
    side_t           first_q, first_d, second_q, second_d;
    logic [2:0]      comp_typ_q, comp_typ_d;
    logic [1:0]      base, next_idx, head, cand_cls;
    logic            next_ok;

    assign valid_v        = {cpl_valid, np_valid, p_valid};
    assign fc_v           = {cpl_fc_ok, np_fc_ok, p_fc_ok};
    assign side_v[CLS_P]   = '{trans: CLS_P,   ro: p_ro,   ido: p_ido,   id: p_id};
    assign side_v[CLS_NP]  = '{trans: CLS_NP,  ro: np_ro,  ido: np_ido,  id: np_id};
    assign side_v[CLS_CPL] = '{trans: CLS_CPL, ro: cpl_ro, ido: cpl_ido, id: cpl_id};

    // A granted class stays listed until its TLP completes, even if its valid drops.
    assign append_req = valid_v & ~listed;
    assign remove_req = (listed & ~valid_v & ~grant_q)
                      | ((state_q == BUSY && tlp_done) ? grant_q : 3'b000);

    tx_age_list u_age_list (
        .clk        (clk),
        .rst        (rst),
        .append_req (append_req),
        .remove_req (remove_req),
        .slots      (slots),
        .count      (count),
        .listed     (listed)
    );

    // Next younger slot holding credit, searched after the head (EVAL) or after the current candidate.
    always_comb begin
        base     = (state_q == EVAL) ? 2'd0 : cand_q;
        next_ok  = 1'b0;
        next_idx = '0;
        for (int unsigned i = 1; i < 3; i++) begin
            if (!next_ok && i > 32'(base) && i < 32'(count)
                && fc_v[slots[i[1:0]]] && valid_v[slots[i[1:0]]]) begin
                next_ok  = 1'b1;
                next_idx = i[1:0];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cand_d     = cand_q;
        pair_d     = pair_q;
        starve_d   = starve_q;
        grant_d    = grant_q;
        first_d    = first_q;
        second_d   = second_q;
        comp_typ_d = comp_typ_q;
        head       = slots[0];
        cand_cls   = slots[cand_q];
        case (state_q)
            IDLE: if (count != 2'd0) state_d = EVAL;
            EVAL: begin
                if (count == 2'd0) begin
                    state_d = IDLE;
                end else if (fc_v[head] && valid_v[head]) begin
                    state_d  = GRANT;
                    grant_d  = cls_onehot(head);
                    starve_d = '0;
                end else if (next_ok && 32'(starve_q) < STARVE_LIMIT) begin
                    state_d    = CHECK;
                    cand_d     = next_idx;
                    pair_d     = '0;
                    first_d    = side_v[head];
                    second_d   = side_v[slots[next_idx]];
                    comp_typ_d = cpl_comp_typ;
                end
            end
            CHECK: begin
                if (ord.ordering_result && fc_v[cand_cls] && valid_v[cand_cls] && cand_q < count) begin
                    if (pair_q + 2'd1 == cand_q) begin
                        state_d = GRANT;
                        grant_d = cls_onehot(cand_cls);
                        if (32'(starve_q) < STARVE_LIMIT) starve_d = starve_q + SW'(1);
                    end else begin
                        pair_d     = pair_q + 2'd1;
                        first_d    = side_v[slots[pair_q + 2'd1]];
                        second_d   = side_v[cand_cls];
                        comp_typ_d = cpl_comp_typ;
                    end
                end else if (next_ok) begin
                    cand_d     = next_idx;
                    pair_d     = '0;
                    first_d    = side_v[head];
                    second_d   = side_v[slots[next_idx]];
                    comp_typ_d = cpl_comp_typ;
                end else begin
                    state_d = EVAL;
                end
            end
            GRANT: state_d = BUSY;
            BUSY: begin
                if (tlp_done) begin
                    grant_d = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cand_q     <= '0;
            pair_q     <= '0;
            starve_q   <= '0;
            grant_q    <= '0;
            first_q    <= '0;
            second_q   <= '0;
            comp_typ_q <= '0;
        end else begin
            state_q    <= state_d;
            cand_q     <= cand_d;
            pair_q     <= pair_d;
            starve_q   <= starve_d;
            grant_q    <= grant_d;
            first_q    <= first_d;
            second_q   <= second_d;
            comp_typ_q <= comp_typ_d;
        end
    end

    assign grant            = grant_q;
    assign ord.first_trans  = Req_Type_t'(first_q.trans);
    assign ord.first_ro     = first_q.ro;
    assign ord.first_ido    = first_q.ido;
    assign ord.first_id     = first_q.id;
    assign ord.second_trans = Req_Type_t'(second_q.trans);
    assign ord.second_ro    = second_q.ro;
    assign ord.second_ido   = second_q.ido;
    assign ord.second_id    = second_q.id;
    assign ord.comp_typ     = comp_typ_q;

endmodule

// File: tb/tb_tx_ordering_scheduler.sv
// Self-checking bench for tx_ordering_scheduler; the bench plays the ordering checker
// from a pass table and predicts grants and query pairs from arrival order and credit.
module tb_tx_ordering_scheduler;
    import Tx_Arbiter_Package::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  vld, fc, ro_v, ido_v;
    logic [2:0][15:0] id_arr;
    logic [2:0]  cpl_comp_typ;
    logic [2:0]  grant;
    logic        tlp_done;
    logic [8:0]  pass_tbl;
    logic        ord_res;
    logic [3:0]  pidx;
    logic [42:0] ord_obs;

    int n_checks = 0;
    int n_fail   = 0;

    ordering_if ord_if();

    tx_ordering_scheduler #(.STARVE_LIMIT(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .p_valid      (vld[0]),
        .np_valid     (vld[1]),
        .cpl_valid    (vld[2]),
        .p_ro         (ro_v[0]),
        .p_ido        (ido_v[0]),
        .np_ro        (ro_v[1]),
        .np_ido       (ido_v[1]),
        .cpl_ro       (ro_v[2]),
        .cpl_ido      (ido_v[2]),
        .p_id         (id_arr[0]),
        .np_id        (id_arr[1]),
        .cpl_id       (id_arr[2]),
        .cpl_comp_typ (cpl_comp_typ),
        .p_fc_ok      (fc[0]),
        .np_fc_ok     (fc[1]),
        .cpl_fc_ok    (fc[2]),
        .grant        (grant),
        .tlp_done     (tlp_done),
        .ord          (ord_if)
    );

    always #5 clk = ~clk;

    // Ordering checker model: pass_tbl[first*3 + second].
    always_comb begin
        pidx    = {2'b00, ord_if.first_trans} * 4'd3 + {2'b00, ord_if.second_trans};
        ord_res = 1'b0;
        if (pidx < 4'd9) ord_res = pass_tbl[pidx];
    end
    assign ord_if.ordering_result = ord_res;

    assign ord_obs = {ord_if.first_trans, ord_if.first_ro, ord_if.first_ido, ord_if.first_id,
                      ord_if.second_trans, ord_if.second_ro, ord_if.second_ido, ord_if.second_id,
                      ord_if.comp_typ};

    function automatic logic [42:0] exp_pair(input int f, input int s);
        logic [1:0] fc2, sc2;
        fc2 = f[1:0];
        sc2 = s[1:0];
        return {fc2, ro_v[fc2], ido_v[fc2], id_arr[fc2], sc2, ro_v[sc2], ido_v[sc2], id_arr[sc2], cpl_comp_typ};
    endfunction

    function automatic logic [2:0] oh(input int c);
        logic [2:0] r;
        r = 3'b000;
        r[c[1:0]] = 1'b1;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; vld = '0; fc = '0; tlp_done = 1'b0;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic wait_grant(input int max_cyc, output bit got);
        got = 1'b0;
        for (int w = 0; w < max_cyc && !got; w++) begin
            step();
            if (grant != 3'b000) got = 1'b1;
        end
    endtask

    task automatic wait_drop(input int max_cyc, output bit dropped);
        dropped = 1'b0;
        for (int w = 0; w < max_cyc && !dropped; w++) begin
            step();
            if (grant == 3'b000) dropped = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; vld = '0; fc = '0; tlp_done = 1'b0;
        step(); step();
        n_checks++;
        if (grant !== 3'b000) begin n_fail++; $display("FAIL reset_grant: got %b expected 000", grant); end
        n_checks++;
        if (ord_obs !== 43'd0) begin n_fail++; $display("FAIL reset_ord: got %h expected 0", ord_obs); end
        rst = 1'b0;
    endtask

    task automatic test_single_posted();
        bit dropped_ok;
        do_reset();
        vld[0] = 1'b1; fc[0] = 1'b1;
        dropped_ok = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            logic [2:0] want;
            step();
            tlp_done = 1'b0;
            if (c == 3) tlp_done = 1'b1;          // GRANT state: must be ignored
            if (c == 6) begin tlp_done = 1'b1; vld[0] = 1'b0; end
            want = (c >= 3 && c <= 6) ? 3'b001 : 3'b000;
            n_checks++;
            if (grant !== want) begin
                n_fail++;
                $display("FAIL single_p_cycle%0d: got %b expected %b", c, grant, want);
            end
        end
        tlp_done = 1'b0;
    endtask

    task automatic test_bypass(input bit pass);
        bit got;
        do_reset();
        ro_v = 3'b010; ido_v = 3'b001; id_arr = {16'h0C0C, 16'h0B0B, 16'h0A0A}; cpl_comp_typ = 3'b011;
        pass_tbl = pass ? 9'h1FF : 9'h1FD;        // (P,NP) entry is bit 1
        vld[0] = 1'b1;
        step();
        vld[1] = 1'b1; fc[1] = 1'b1;
        step(); step();
        n_checks++;
        if (ord_obs !== exp_pair(0, 1)) begin n_fail++; $display("FAIL bypass_pair: got %h expected %h", ord_obs, exp_pair(0, 1)); end
        if (pass) begin
            step();
            n_checks++;
            if (grant !== 3'b010) begin n_fail++; $display("FAIL bypass_grant: got %b expected 010", grant); end
        end else begin
            got = 1'b0;
            for (int c = 0; c < 10; c++) begin step(); if (grant != 3'b000) got = 1'b1; end
            n_checks++;
            if (got) begin n_fail++; $display("FAIL blocked_no_grant: got %b expected 000", grant); end
            fc[0] = 1'b1;
            wait_grant(12, got);
            n_checks++;
            if (grant !== 3'b001) begin n_fail++; $display("FAIL blocked_head_grant: got %b expected 001", grant); end
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        ro_v = 3'b101; ido_v = 3'b110; id_arr = {16'h3333, 16'h2222, 16'h1111};
        cpl_comp_typ = 3'b010; pass_tbl = 9'h1FF;
        vld = 3'b111; fc = 3'b100;
        step(); step(); step();
        n_checks++;
        if (ord_obs !== exp_pair(0, 2)) begin n_fail++; $display("FAIL simul_pair0: got %h expected %h", ord_obs, exp_pair(0, 2)); end
        step();
        n_checks++;
        if (ord_obs !== exp_pair(1, 2)) begin n_fail++; $display("FAIL simul_pair1: got %h expected %h", ord_obs, exp_pair(1, 2)); end
        n_checks++;
        if (grant !== 3'b000) begin n_fail++; $display("FAIL simul_early: got %b expected 000", grant); end
        step();
        n_checks++;
        if (grant !== 3'b100) begin n_fail++; $display("FAIL simul_grant: got %b expected 100", grant); end
    endtask

    task automatic test_starvation();
        int bypass;
        bit got, dropped, stuck, odd;
        do_reset();
        pass_tbl = 9'h1FF;
        vld = 3'b011; fc = 3'b010;
        bypass = 0; stuck = 1'b0; odd = 1'b0;
        for (int g = 0; g < 12 && !stuck && !odd; g++) begin
            wait_grant(15, got);
            if (!got) stuck = 1'b1;
            else begin
                if (grant == 3'b010) bypass++; else odd = 1'b1;
                tlp_done = 1'b1;
                wait_drop(6, dropped);
                tlp_done = 1'b0;
            end
        end
        n_checks++;
        if (bypass != 8) begin n_fail++; $display("FAIL starve_bypasses: got %0d expected 8", bypass); end
        n_checks++;
        if (!stuck || odd) begin n_fail++; $display("FAIL starve_hold: got grant %b expected none", grant); end
        fc[0] = 1'b1;
        wait_grant(15, got);
        n_checks++;
        if (grant !== 3'b001) begin n_fail++; $display("FAIL starve_head: got %b expected 001", grant); end
    endtask

    task automatic test_back_to_back();
        bit got, dropped;
        int gap;
        do_reset();
        vld[0] = 1'b1; fc[0] = 1'b1;
        wait_grant(10, got);
        step();
        tlp_done = 1'b1;
        wait_drop(6, dropped);
        tlp_done = 1'b0;
        gap = 0; got = 1'b0;
        for (int w = 0; w < 10 && !got; w++) begin step(); gap++; if (grant != 3'b000) got = 1'b1; end
        n_checks++;
        if (!dropped || !got || gap != 3 || grant !== 3'b001) begin
            n_fail++;
            $display("FAIL back_to_back_gap: got %0d cycles grant %b expected 3 cycles grant 001", gap, grant);
        end
    endtask

    task automatic test_reset_in_busy();
        bit got;
        do_reset();
        pass_tbl = 9'h1FF; id_arr = {16'hFACE, 16'hBEEF, 16'hA5A5}; ro_v = 3'b111; ido_v = 3'b111;
        cpl_comp_typ = 3'b110;
        vld = 3'b011; fc = 3'b010;
        wait_grant(12, got);
        step(); step();
        rst = 1'b1; vld = '0; fc = '0;
        step();
        n_checks++;
        if (grant !== 3'b000) begin n_fail++; $display("FAIL busy_reset_grant: got %b expected 000", grant); end
        n_checks++;
        if (ord_obs !== 43'd0) begin n_fail++; $display("FAIL busy_reset_ord: got %h expected 0", ord_obs); end
        rst = 1'b0;
        vld[0] = 1'b1; fc[0] = 1'b1;
        step(); step(); step();
        n_checks++;
        if (grant !== 3'b001) begin n_fail++; $display("FAIL post_reset_latency: got %b expected 001", grant); end
    endtask

    task automatic test_random_ordering(input int iters);
        int order[3];
        int n, g, head, tmp, j;
        int exp_q[$];
        logic [2:0] fcv;
        bit ok, got, dropped;
        for (int it = 0; it < iters; it++) begin
            do_reset();
            order = '{0, 1, 2};
            for (int i = 2; i > 0; i--) begin
                j = $urandom_range(0, i); tmp = order[i]; order[i] = order[j]; order[j] = tmp;
            end
            n = $urandom_range(1, 3);
            ro_v = 3'($urandom); ido_v = 3'($urandom);
            for (int c = 0; c < 3; c++) id_arr[c] = 16'($urandom);
            cpl_comp_typ = 3'($urandom_range(1, 6));
            pass_tbl = 9'($urandom);
            for (int k = 0; k < n; k++) begin vld[order[k]] = 1'b1; step(); end
            step(); step(); step();
            fcv = 3'($urandom) & vld;
            fcv[order[$urandom_range(0, n - 1)]] = 1'b1;
            head = order[0];
            // Expected: head if credited, else first credited younger class clearing all older pairs.
            exp_q.delete(); g = -1;
            if (fcv[head]) g = head;
            else begin
                for (int k = 1; k < n && g < 0; k++) begin
                    if (fcv[order[k]]) begin
                        ok = 1'b1;
                        for (int m = 0; m < k && ok; m++) begin
                            exp_q.push_back(order[m] * 4 + order[k]);
                            if (!pass_tbl[order[m] * 3 + order[k]]) ok = 1'b0;
                        end
                        if (ok) g = order[k];
                    end
                end
            end
            fc = fcv;
            foreach (exp_q[q]) begin
                step();
                n_checks++;
                if (ord_obs !== exp_pair(exp_q[q] / 4, exp_q[q] % 4) || grant !== 3'b000) begin
                    n_fail++;
                    $display("FAIL rand%0d_pair%0d: got %h/%b expected %h/000", it, q, ord_obs, grant,
                             exp_pair(exp_q[q] / 4, exp_q[q] % 4));
                end
            end
            if (g >= 0) begin
                step();
                n_checks++;
                if (grant !== oh(g)) begin n_fail++; $display("FAIL rand%0d_grant: got %b expected %b", it, grant, oh(g)); end
            end else begin
                got = 1'b0;
                for (int c = 0; c < 8; c++) begin step(); if (grant != 3'b000) got = 1'b1; end
                n_checks++;
                if (got) begin n_fail++; $display("FAIL rand%0d_blocked: got %b expected 000", it, grant); end
                g = head;
                fc[head] = 1'b1;
                wait_grant(12, got);
                n_checks++;
                if (grant !== oh(g)) begin n_fail++; $display("FAIL rand%0d_head: got %b expected %b", it, grant, oh(g)); end
            end
            step();
            n_checks++;
            if (grant !== oh(g)) begin n_fail++; $display("FAIL rand%0d_hold: got %b expected %b", it, grant, oh(g)); end
            tlp_done = 1'b1; vld[g] = 1'b0;
            wait_drop(4, dropped);
            tlp_done = 1'b0;
            n_checks++;
            if (!dropped) begin n_fail++; $display("FAIL rand%0d_release: got %b expected 000", it, grant); end
        end
    endtask

    initial begin
        rst = 1'b1; vld = '0; fc = '0; tlp_done = 1'b0;
        ro_v = '0; ido_v = '0; id_arr = '0; cpl_comp_typ = '0; pass_tbl = '1;
        test_reset();
        test_single_posted();
        test_bypass(1'b1);
        test_bypass(1'b0);
        test_simultaneous();
        test_starvation();
        test_back_to_back();
        test_reset_in_busy();
        test_random_ordering(40);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
